// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared widths and FSM state encoding for the program loader.
// Rev 1.0
`default_nettype none
package prog_loader_pkg;
  localparam int INSTR_W = 9;
  localparam int BYTE_W  = 8;
  localparam int LEN_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    W_LO   = 3'd3,
    W_HI   = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6
  } state_t;
endpackage
`default_nettype wire

// File: rtl/instr_RAM.sv
// instr_RAM: 2**D x 9 instruction store, synchronous write, combinational read.
// Rev 1.0
`default_nettype none
module instr_RAM
  import prog_loader_pkg::*;
#(
  parameter int D = 10
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [D-1:0]       wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [D-1:0]       prog_ctr,
  output logic [INSTR_W-1:0] mach_code
);
  logic [INSTR_W-1:0] core [0:(1<<D)-1];

  always_ff @(posedge clk) begin
    if (wr_en) core[wr_addr] <= wr_data;
  end

  assign mach_code = core[prog_ctr];
endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader that fills instr_RAM and holds the core until done.
// Rev 1.0 -- optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
`default_nettype none
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int D = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D-1:0]       prog_ctr,
  output logic [INSTR_W-1:0] mach_code,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [D:0]         word_cnt
);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t LAST_ST = CHK;
`else
  localparam state_t LAST_ST = DONE;
`endif

  state_t             state, next_state;
  logic [BYTE_W-1:0]  lo;
  logic [LEN_W-1:0]   remaining;
  logic [D:0]         cnt;
  logic               err;
  logic               xfer;
  logic               full;
  logic               wr_en;
  logic [LEN_W-1:0]   len_n;

  assign xfer  = in_valid && in_ready;
  assign len_n = {in_data, lo};
  // Once cnt reaches 2**D further words are consumed but dropped.
  assign full  = cnt[D];
  assign wr_en = xfer && (state == W_HI) && !full;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE:   if (start) next_state = LEN_LO;
      LEN_LO: begin
        in_ready = 1'b1;
        if (xfer) next_state = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (xfer) next_state = (len_n == '0) ? LAST_ST : W_LO;
      end
      W_LO: begin
        in_ready = 1'b1;
        if (xfer) next_state = W_HI;
      end
      W_HI: begin
        in_ready = 1'b1;
        if (xfer) next_state = (remaining == LEN_W'(1)) ? LAST_ST : W_LO;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        if (xfer) next_state = DONE;
      end
`endif
      DONE:   if (start) next_state = LEN_LO;
      default: next_state = IDLE;
    endcase
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] chk;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      lo        <= '0;
      remaining <= '0;
      cnt       <= '0;
      err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      if (start && (state == IDLE || state == DONE)) begin
        cnt <= '0;
        err <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk <= '0;
`endif
      end
      if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
        chk <= chk ^ in_data;
`endif
        case (state)
          LEN_LO, W_LO: lo <= in_data;
          LEN_HI:       remaining <= len_n;
          W_HI: begin
            remaining <= remaining - LEN_W'(1);
            if (full) err <= 1'b1;
            else      cnt <= cnt + (D+1)'(1);
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          CHK:          if (in_data != chk) err <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  instr_RAM #(.D(D)) u_ram (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (cnt[D-1:0]),
    .wr_data   ({in_data[0], lo}),
    .prog_ctr  (prog_ctr),
    .mach_code (mach_code)
  );

  assign cpu_hold  = (state != DONE);
  assign load_done = (state == DONE);
  assign load_err  = err;
  assign word_cnt  = cnt;
endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized stream stimulus checked every cycle against a byte-level model.
`default_nettype none
module tb_prog_loader;
  localparam int D     = 2;
  localparam int DEPTH = 1 << D;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int CHKB = 1;
`else
  localparam int CHKB = 0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [7:0]     in_data = 8'h00;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [D-1:0]   prog_ctr = '0;
  logic [8:0]     mach_code;
  logic           cpu_hold, load_done, load_err;
  logic [D:0]     word_cnt;

  prog_loader #(.D(D)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .prog_ctr(prog_ctr),
    .mach_code(mach_code), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Byte-level model: a load is just a count of bytes received against the stream layout.
  bit         m_loading = 0, m_done = 0, m_err = 0;
  int         m_cnt = 0, m_bidx = 0, m_n = 0, m_k;
  logic [7:0] m_lo, m_xor;
  logic [8:0] m_mem [DEPTH];
  bit         m_known [DEPTH];

  always @(posedge clk) begin
    if (reset) begin
      m_loading = 0; m_done = 0; m_err = 0; m_cnt = 0;
    end else if (!m_loading) begin
      if (start) begin
        m_loading = 1; m_done = 0; m_err = 0; m_cnt = 0;
        m_bidx = 0; m_xor = 8'h00; m_n = 0;
      end
    end else if (in_valid) begin
      if (m_bidx == 0) m_n = int'(in_data);
      else if (m_bidx == 1) m_n = m_n + int'(in_data) * 256;
      else if (m_bidx < 2 + 2 * m_n) begin
        m_k = (m_bidx - 2) / 2;
        if (m_bidx % 2 == 0) m_lo = in_data;
        else if (m_k < DEPTH) begin
          m_mem[m_k] = {in_data[0], m_lo};
          m_known[m_k] = 1;
          m_cnt = m_k + 1;
        end else m_err = 1;
      end else if (in_data != m_xor) m_err = 1;
      m_xor = m_xor ^ in_data;
      m_bidx++;
      if (m_bidx >= 2 && m_bidx == 2 + 2 * m_n + CHKB) begin
        m_loading = 0; m_done = 1;
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",  32'(in_ready),  32'(m_loading));
      check("cpu_hold",  32'(cpu_hold),  32'(!m_done));
      check("load_done", 32'(load_done), 32'(m_done));
      check("word_cnt",  32'(word_cnt),  32'(m_cnt));
      if (m_done) check("load_err", 32'(load_err), 32'(m_err));
      if (m_known[prog_ctr]) check("mach_code", 32'(mach_code), 32'(m_mem[prog_ctr]));
    end
  end

  bit pc_rand = 1;
  always @(posedge clk) begin
    #1;
    if (pc_rand) prog_ctr = D'($urandom);
  end

  task automatic peek(input int addr, input logic [8:0] exp, input string name);
    pc_rand = 0;
    prog_ctr = D'(addr);
    #1;
    check(name, 32'(mach_code), 32'(exp));
    pc_rand = 1;
  endtask

  // gap: 0 = back-to-back, 1 = random idle cycles, 2 = idle cycle before every byte
  task automatic send(input logic [7:0] b, input int gap);
    bit rdy;
    int n = 0;
    if (gap == 2 || (gap == 1 && $urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0; in_data = 8'($urandom);
      @(posedge clk); #2;
    end
    in_valid = 1'b1; in_data = b;
    start = ($urandom_range(0, 5) == 0);
    do begin
      rdy = in_ready;
      @(posedge clk); #2;
      n++;
    end while (!rdy && n < 40);
    if (!rdy) check("handshake_timeout", 32'(rdy), 32'd1);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    in_valid = 1'($urandom); in_data = 8'($urandom);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; in_valid = 1'b0;
  endtask

  logic [8:0] wq[$];
  bit rand_hi = 0;

  task automatic load(input int n, input int gap, input int chkb);
    logic [7:0] q[$];
    logic [7:0] x;
    x = 8'h00;
    do_start();
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      q.push_back(wq[i][7:0]);
      q.push_back({rand_hi ? 7'($urandom) : 7'h00, wq[i][8]});
    end
    foreach (q[i]) x = x ^ q[i];
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(chkb < 0 ? x : 8'(chkb));
`endif
    foreach (q[i]) send(q[i], gap);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    cmp_en = 1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_cpu_hold",  32'(cpu_hold),  32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_word_cnt",  32'(word_cnt),  32'd0);
    repeat (3) @(posedge clk);
    #2;

    wq = '{9'h03E, 9'h066, 9'h07A};
    load(3, 0, -1);
    check("t1_word_cnt", 32'(word_cnt), 32'd3);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_err", 32'(load_err), 32'd0);
    peek(0, 9'h03E, "t1_mem0");
    peek(1, 9'h066, "t1_mem1");
    peek(2, 9'h07A, "t1_mem2");

    wq = '{9'h1FE};
    load(1, 2, -1);
    check("t2_word_cnt", 32'(word_cnt), 32'd1);
    peek(0, 9'h1FE, "t2_mem0");
    peek(1, 9'h066, "t2_mem1");

    load(0, 1, -1);
    check("t3_word_cnt", 32'(word_cnt), 32'd0);
    check("t3_done", 32'(load_done), 32'd1);
    peek(0, 9'h1FE, "t3_mem0");

    wq = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005};
    load(5, 1, -1);
    check("t4_word_cnt", 32'(word_cnt), 32'd4);
    check("t4_err", 32'(load_err), 32'd1);
    peek(0, 9'h001, "t4_mem0");
    peek(3, 9'h004, "t4_mem3");

    do_start();
    send(8'h03, 0); send(8'h00, 0); send(8'hAA, 1); send(8'h00, 1);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    check("t5_hold", 32'(cpu_hold), 32'd1);
    check("t5_done", 32'(load_done), 32'd0);
    check("t5_ready", 32'(in_ready), 32'd0);
    peek(0, 9'h0AA, "t5_mem0");
    wq = '{9'h0BB, 9'h1CC, 9'h0DD};
    load(3, 1, -1);
    check("t5_word_cnt", 32'(word_cnt), 32'd3);
    peek(1, 9'h1CC, "t5_mem1");

`ifdef PROG_LOADER_CHECKSUM_EN
    wq = '{9'h03E};
    load(1, 0, 8'h3F);
    check("t6_good_err", 32'(load_err), 32'd0);
    check("t6_good_done", 32'(load_done), 32'd1);
    load(1, 0, 8'h00);
    check("t6_bad_err", 32'(load_err), 32'd1);
    check("t6_bad_done", 32'(load_done), 32'd1);
`endif

    rand_hi = 1;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 7);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(9'($urandom));
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom); in_data = 8'($urandom);
        @(posedge clk); #2;
      end
      in_valid = 1'b0;
      load(n, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
